rr_grant_arbiter: RTL and testbench
===================================

# rr_grant_arbiter

Registered request/grant arbiter that turns a request vector into a one-hot grant plus its encoded index, with optional round-robin rotation and grant hold. It sits between N requesters and a shared resource (mux, port, bus). It drives the select for the downstream mux and consumes the per-port acknowledge from the resource side. Selection uses the combinational priority encoding already in the codebase; this block adds the state: grant register, hold/release handshake and rotation mask.

## Interface
Parameters:
- PORTS, 4, number of requesters (≥1).
- ARB_TYPE_ROUND_ROBIN, 0, 1 = rotate priority after each grant; 0 = fixed priority.
- ARB_BLOCK, 0, 1 = hold grant until released; 0 = re-arbitrate every cycle.
- ARB_BLOCK_ACK, 1, only if ARB_BLOCK=1. 1 = release on acknowledge; 0 = release when the granted request drops.
- ARB_LSB_HIGH_PRIORITY, 0, 1 = index 0 highest priority; 0 = index PORTS-1 highest.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- request, input, PORTS, per-port request level.
- acknowledge, input, PORTS, per-port release pulse (used when ARB_BLOCK=ARB_BLOCK_ACK=1).
- grant, output, PORTS, registered one-hot grant, zero when idle.
- grant_valid, output, 1, registered; high iff grant≠0.
- grant_encoded, output, $clog2(PORTS), registered index of granted port; 0 when idle.

## Operation
- Internal state:
  - grant register (grant, grant_valid, grant_encoded).
  - mask register, PORTS bits.
- Winner selection:
  - masked = request & mask.
  - If masked≠0, winner = highest-priority bit of masked; else winner = highest-priority bit of request.
- Fixed priority (ARB_TYPE_ROUND_ROBIN=0): mask is ignored and held at all ones.
- Round-robin mask update on every new grant of index k:
  - ARB_LSB_HIGH_PRIORITY=0: mask bit i = (i<k).
  - ARB_LSB_HIGH_PRIORITY=1: mask bit i = (i>k).
  - The winner therefore becomes lowest priority.
- States, implicit in grant_valid:
  - IDLE: request≠0 → load winner, go to GRANTED.
  - GRANTED, ARB_BLOCK=0: re-evaluate every cycle. Load winner if request≠0, else return to IDLE.
  - GRANTED, ARB_BLOCK=1, ARB_BLOCK_ACK=1: hold while acknowledge[grant_encoded]=0, regardless of request. Release when it is 1.
  - GRANTED, ARB_BLOCK=1, ARB_BLOCK_ACK=0: hold while request[grant_encoded]=1. Release when it is 0.
  - On release: arbitrate in the same cycle with the granted port's request bit excluded. Load the new winner if any, else go to IDLE. There are no bubbles between back-to-back grants.
- acknowledge bits of non-granted ports are ignored.
- acknowledge while idle is ignored.
- Fixed-priority blocking mode: a higher-priority request never preempts a held grant.
- Exactly one grant bit is ever set.

## Timing
- All outputs are registered.
- A request seen at edge t produces a grant visible after edge t (one-cycle latency).
- Release observed at edge t → new grant (or idle) visible after edge t.
- Reset values: grant=0, grant_valid=0, grant_encoded=0, mask=all ones. rst has priority over all other inputs.
- rst asserted mid-grant: outputs return to zero after the next edge. The first grant after reset uses raw priority.
- PORTS=1: grant_encoded is 1 bit wide, constant 0.
- Simultaneous release and new requests: the resolution rule under Operation applies.

## Structure
- No shared package is required.
- Index width and the mask-update rule are local constants/functions.
- Two instances of the codebase's existing priority_encoder module serve as the natural sub-module: one on masked, one on request. Their encoded and unencoded outputs feed the grant register.
- The grant register and the mask update live in this module.

## Test plan
All scenarios use PORTS=4.
- Reset: hold rst 3 cycles with request=4'b1111 -> grant=0, grant_valid=0, grant_encoded=0 throughout and one cycle after release of rst.
- Fixed MSB priority, ARB_BLOCK=0: request=4'b0101 -> grant=4'b0100, grant_encoded=2 one cycle later. Then request=4'b0001 -> grant=4'b0001.
- Round-robin MSB priority, ARB_BLOCK=0: request=4'b1111 held -> grant sequence 1000, 0100, 0010, 0001, 1000 on consecutive cycles.
- ARB_BLOCK=1, ARB_BLOCK_ACK=1: request=4'b0011 -> grant=0010.
  - Drop request[1], raise request[3], keep acknowledge=0 for 5 cycles -> grant stays 0010.
  - acknowledge=4'b0010 for 1 cycle -> grant=1000 the next cycle, no idle cycle.
- ARB_BLOCK=1, ARB_BLOCK_ACK=0: request=4'b0100 -> grant=0100. request→0 -> grant=0 and grant_valid=0 next cycle.
- While grant=0010: pulse acknowledge=4'b0001 -> ignored, grant unchanged. Then assert rst 1 cycle -> grant=0. With request=4'b1010 afterwards -> grant=1000 (raw priority; mask was reset).

Source files
------------

// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
package rr_grant_arbiter_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } arb_state_e;

  // Index width that stays at least one bit wide for a single port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_priority_encoder.sv
// Combinational priority encoder: highest-priority set bit as index and one-hot.
module rr_grant_arbiter_priority_encoder
  import rr_grant_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH             = 4,
  parameter bit          LSB_HIGH_PRIORITY = 1'b0,
  localparam int unsigned IDX_W            = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] req_i,
  output logic             valid_c,
  output logic [IDX_W-1:0] encoded_c,
  output logic [WIDTH-1:0] onehot_c
);

  assign valid_c = |req_i;

  // Scan toward the highest-priority end so the last hit wins.
  always_comb begin
    encoded_c = '0;
    onehot_c  = '0;
    if (LSB_HIGH_PRIORITY) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (req_i[i]) begin
          encoded_c = IDX_W'(i);
          onehot_c  = '0;
          onehot_c[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (req_i[i]) begin
          encoded_c = IDX_W'(i);
          onehot_c  = '0;
          onehot_c[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered request/grant arbiter with optional round-robin rotation and grant hold.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
  parameter int unsigned PORTS                 = 4,
  parameter bit          ARB_TYPE_ROUND_ROBIN  = 1'b0,
  parameter bit          ARB_BLOCK             = 1'b0,
  parameter bit          ARB_BLOCK_ACK         = 1'b1,
  parameter bit          ARB_LSB_HIGH_PRIORITY = 1'b0,
  localparam int unsigned IDX_W                = idx_width(PORTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_encoded
);

  arb_state_e       state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] enc_q, enc_d;
  logic [PORTS-1:0] mask_q, mask_d;

  logic [PORTS-1:0] req_eff_c, masked_c;
  logic             m_valid_c, r_valid_c, release_c;
  logic [IDX_W-1:0] m_enc_c, r_enc_c, win_enc_c;
  logic [PORTS-1:0] m_oh_c, r_oh_c, win_oh_c;

  // After a grant the winner drops to lowest priority.
  function automatic logic [PORTS-1:0] rr_mask(input logic [IDX_W-1:0] k);
    logic [PORTS-1:0] m;
    m = '0;
    for (int i = 0; i < int'(PORTS); i++) begin
      m[i] = ARB_LSB_HIGH_PRIORITY ? (i > int'(k)) : (i < int'(k));
    end
    return m;
  endfunction

  // A released holder must not win the arbitration in its own release cycle.
  assign req_eff_c = (ARB_BLOCK && (state_q == ST_GRANTED)) ? (request & ~grant_q) : request;
  assign masked_c  = req_eff_c & mask_q;

  rr_grant_arbiter_priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
  ) u_pe_masked (
    .req_i     (masked_c),
    .valid_c   (m_valid_c),
    .encoded_c (m_enc_c),
    .onehot_c  (m_oh_c)
  );

  rr_grant_arbiter_priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
  ) u_pe_raw (
    .req_i     (req_eff_c),
    .valid_c   (r_valid_c),
    .encoded_c (r_enc_c),
    .onehot_c  (r_oh_c)
  );

  assign win_oh_c  = m_valid_c ? m_oh_c  : r_oh_c;
  assign win_enc_c = m_valid_c ? m_enc_c : r_enc_c;

  // Next-state: decide whether the current grant is released, then reload.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    enc_d     = enc_q;
    mask_d    = mask_q;
    release_c = 1'b0;
    case (state_q)
      ST_IDLE: release_c = 1'b1;
      ST_GRANTED: begin
        if (!ARB_BLOCK)        release_c = 1'b1;
        else if (ARB_BLOCK_ACK) release_c = acknowledge[enc_q];
        else                   release_c = !request[enc_q];
      end
      default: release_c = 1'b1;
    endcase
    if (release_c) begin
      if (r_valid_c) begin
        state_d = ST_GRANTED;
        grant_d = win_oh_c;
        enc_d   = win_enc_c;
        if (ARB_TYPE_ROUND_ROBIN) mask_d = rr_mask(win_enc_c);
      end else begin
        state_d = ST_IDLE;
        grant_d = '0;
        enc_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      enc_q   <= '0;
      mask_q  <= '1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      enc_q   <= enc_d;
      mask_q  <= mask_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = (state_q == ST_GRANTED);
  assign grant_encoded = enc_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench: four arbiter configurations run side by side on one clock.
module tb_rr_grant_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // fix: fixed MSB, no hold | rr: round-robin MSB, no hold
  // ack: hold until acknowledge | rq: hold until request drops
  logic [3:0] req_fix, req_rr, req_ack, req_rq;
  logic [3:0] ack_fix, ack_rr, ack_ack, ack_rq;
  logic [3:0] g_fix, g_rr, g_ack, g_rq;
  logic       v_fix, v_rr, v_ack, v_rq;
  logic [1:0] e_fix, e_rr, e_ack, e_rq;

  rr_grant_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b0), .ARB_BLOCK(1'b0),
                     .ARB_BLOCK_ACK(1'b1), .ARB_LSB_HIGH_PRIORITY(1'b0)) u_fix (
    .clk(clk), .rst(rst), .request(req_fix), .acknowledge(ack_fix),
    .grant(g_fix), .grant_valid(v_fix), .grant_encoded(e_fix));

  rr_grant_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b1), .ARB_BLOCK(1'b0),
                     .ARB_BLOCK_ACK(1'b1), .ARB_LSB_HIGH_PRIORITY(1'b0)) u_rr (
    .clk(clk), .rst(rst), .request(req_rr), .acknowledge(ack_rr),
    .grant(g_rr), .grant_valid(v_rr), .grant_encoded(e_rr));

  rr_grant_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b0), .ARB_BLOCK(1'b1),
                     .ARB_BLOCK_ACK(1'b1), .ARB_LSB_HIGH_PRIORITY(1'b0)) u_ack (
    .clk(clk), .rst(rst), .request(req_ack), .acknowledge(ack_ack),
    .grant(g_ack), .grant_valid(v_ack), .grant_encoded(e_ack));

  rr_grant_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b0), .ARB_BLOCK(1'b1),
                     .ARB_BLOCK_ACK(1'b0), .ARB_LSB_HIGH_PRIORITY(1'b0)) u_rq (
    .clk(clk), .rst(rst), .request(req_rq), .acknowledge(ack_rq),
    .grant(g_rq), .grant_valid(v_rq), .grant_encoded(e_rq));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_fix = 4'b1111; req_rr = 4'b1111; req_ack = 4'b1111; req_rq = 4'b1111;
    ack_fix = 4'b0000; ack_rr = 4'b0000; ack_ack = 4'b0000; ack_rq = 4'b0000;

    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_grant_fix", 32'(g_fix), 32'h0);
      chk("rst_valid_fix", 32'(v_fix), 32'h0);
      chk("rst_enc_fix",   32'(e_fix), 32'h0);
      chk("rst_grant_ack", 32'(g_ack), 32'h0);
    end
    rst = 1'b0;
    req_fix = 4'b0101; req_ack = 4'b0011; req_rq = 4'b0100;

    // tick 1
    tick();
    chk("fix_0101_grant", 32'(g_fix), 32'h4);
    chk("fix_0101_enc",   32'(e_fix), 32'h2);
    chk("rr_seq0",        32'(g_rr),  32'h8);
    chk("ack_first",      32'(g_ack), 32'h2);
    chk("rq_first",       32'(g_rq),  32'h4);
    chk("rq_first_valid", 32'(v_rq),  32'h1);
    req_fix = 4'b0001; req_ack = 4'b1001; req_rq = 4'b0000;

    // tick 2
    tick();
    chk("fix_0001_grant", 32'(g_fix), 32'h1);
    chk("fix_0001_enc",   32'(e_fix), 32'h0);
    chk("rr_seq1",        32'(g_rr),  32'h4);
    chk("rr_seq1_enc",    32'(e_rr),  32'h2);
    chk("ack_hold0",      32'(g_ack), 32'h2);
    chk("rq_drop_grant",  32'(g_rq),  32'h0);
    chk("rq_drop_valid",  32'(v_rq),  32'h0);
    chk("rq_drop_enc",    32'(e_rq),  32'h0);

    // ticks 3..6: acknowledge held low, higher request must not preempt
    tick();
    chk("rr_seq2",   32'(g_rr),  32'h2);
    chk("ack_hold1", 32'(g_ack), 32'h2);
    tick();
    chk("rr_seq3",   32'(g_rr),  32'h1);
    chk("ack_hold2", 32'(g_ack), 32'h2);
    tick();
    chk("rr_seq4",   32'(g_rr),  32'h8);
    chk("ack_hold3", 32'(g_ack), 32'h2);
    tick();
    chk("ack_hold4", 32'(g_ack), 32'h2);

    // tick 7: acknowledge on a non-granted port is ignored
    ack_ack = 4'b0001;
    tick();
    chk("ack_wrong_port", 32'(g_ack), 32'h2);
    chk("ack_wrong_enc",  32'(e_ack), 32'h1);

    // tick 8: release with port 3 waiting, no idle bubble
    ack_ack = 4'b0010;
    tick();
    chk("ack_release_grant", 32'(g_ack), 32'h8);
    chk("ack_release_valid", 32'(v_ack), 32'h1);
    chk("ack_release_enc",   32'(e_ack), 32'h3);
    ack_ack = 4'b0000;

    // tick 9: new holder keeps grant
    tick();
    chk("ack_new_hold", 32'(g_ack), 32'h8);
    chk("rr_seq8",      32'(g_rr),  32'h8);

    // mid-grant reset, then raw priority with mask restored
    rst = 1'b1;
    tick();
    chk("rst_mid_ack",   32'(g_ack), 32'h0);
    chk("rst_mid_valid", 32'(v_ack), 32'h0);
    chk("rst_mid_rr",    32'(g_rr),  32'h0);
    rst = 1'b0;
    req_ack = 4'b1010;
    tick();
    chk("post_rst_ack", 32'(g_ack), 32'h8);
    chk("post_rst_rr",  32'(g_rr),  32'h8);
    chk("post_rst_rr_enc", 32'(e_rr), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
